// File: rtl/axi_mem_window.sv
// AXI4 address-window bridge: remaps a 2^WIN_BITS window from the Rocket master onto the PS HP port,
// limits forwarded transactions in flight and answers out-of-window accesses locally with DECERR.
module axi_mem_window #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W = 6,
  parameter logic [ADDR_W-1:0] IN_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] OUT_BASE = 32'h1000_0000,
  parameter int WIN_BITS = 28,
  parameter int MAX_OUT = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              s_ar_valid,
  output logic              s_ar_ready,
  input  logic [ADDR_W-1:0] s_ar_addr,
  input  logic [ID_W-1:0]   s_ar_id,
  input  logic [7:0]        s_ar_len,
  input  logic [2:0]        s_ar_size,
  input  logic [1:0]        s_ar_burst,
  input  logic              s_aw_valid,
  output logic              s_aw_ready,
  input  logic [ADDR_W-1:0] s_aw_addr,
  input  logic [ID_W-1:0]   s_aw_id,
  input  logic [7:0]        s_aw_len,
  input  logic [2:0]        s_aw_size,
  input  logic [1:0]        s_aw_burst,
  input  logic              s_w_valid,
  output logic              s_w_ready,
  input  logic [DATA_W-1:0] s_w_data,
  input  logic [DATA_W/8-1:0] s_w_strb,
  input  logic              s_w_last,
  output logic              s_r_valid,
  input  logic              s_r_ready,
  output logic [ID_W-1:0]   s_r_id,
  output logic [DATA_W-1:0] s_r_data,
  output logic [1:0]        s_r_resp,
  output logic              s_r_last,
  output logic              s_b_valid,
  input  logic              s_b_ready,
  output logic [ID_W-1:0]   s_b_id,
  output logic [1:0]        s_b_resp,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic [ID_W-1:0]   m_ar_id,
  output logic [7:0]        m_ar_len,
  output logic [2:0]        m_ar_size,
  output logic [1:0]        m_ar_burst,
  output logic              m_aw_valid,
  input  logic              m_aw_ready,
  output logic [ADDR_W-1:0] m_aw_addr,
  output logic [ID_W-1:0]   m_aw_id,
  output logic [7:0]        m_aw_len,
  output logic [2:0]        m_aw_size,
  output logic [1:0]        m_aw_burst,
  output logic              m_w_valid,
  input  logic              m_w_ready,
  output logic [DATA_W-1:0] m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic              m_w_last,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  input  logic [ID_W-1:0]   m_r_id,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [1:0]        m_r_resp,
  input  logic              m_r_last,
  input  logic              m_b_valid,
  output logic              m_b_ready,
  input  logic [ID_W-1:0]   m_b_id,
  input  logic [1:0]        m_b_resp
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_OUT);

  typedef enum logic {R_IDLE, R_ERR} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_SINK, W_BERR} wr_state_t;

  function automatic logic in_window(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:WIN_BITS] == IN_BASE[ADDR_W-1:WIN_BITS];
  endfunction

  function automatic logic [ADDR_W-1:0] xlate(input logic [ADDR_W-1:0] a);
    return {OUT_BASE[ADDR_W-1:WIN_BITS], a[WIN_BITS-1:0]};
  endfunction

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  logic ar_full, ar_win, ar_free, aw_full, aw_win, aw_free;
  logic [7:0] rd_cnt, wr_cnt, err_beat;
  logic err_last, b_err, rd_inc, rd_dec, wr_inc, wr_dec;

  assign s_ar_ready = !ar_full;
  assign s_aw_ready = !aw_full;

  // Request slices hold the already-translated address; the window flag decides forward vs error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ar_full <= 1'b0; ar_win <= 1'b0; m_ar_addr <= '0; m_ar_id <= '0;
      m_ar_len <= '0; m_ar_size <= '0; m_ar_burst <= '0;
    end else if (s_ar_valid && s_ar_ready) begin
      ar_full <= 1'b1; ar_win <= in_window(s_ar_addr); m_ar_addr <= xlate(s_ar_addr);
      m_ar_id <= s_ar_id; m_ar_len <= s_ar_len; m_ar_size <= s_ar_size; m_ar_burst <= s_ar_burst;
    end else if (ar_free) begin
      ar_full <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aw_full <= 1'b0; aw_win <= 1'b0; m_aw_addr <= '0; m_aw_id <= '0;
      m_aw_len <= '0; m_aw_size <= '0; m_aw_burst <= '0;
    end else if (s_aw_valid && s_aw_ready) begin
      aw_full <= 1'b1; aw_win <= in_window(s_aw_addr); m_aw_addr <= xlate(s_aw_addr);
      m_aw_id <= s_aw_id; m_aw_len <= s_aw_len; m_aw_size <= s_aw_size; m_aw_burst <= s_aw_burst;
    end else if (aw_free) begin
      aw_full <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  // An out-of-window read already idle-drained can enter R_ERR at capture time.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE: if (rd_cnt == 8'd0 && (ar_full ? !ar_win : (s_ar_valid && !in_window(s_ar_addr))))
                rd_next = R_ERR;
      R_ERR:  if (s_r_ready && err_last) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    err_last   = err_beat == m_ar_len;
    m_ar_valid = ar_full && ar_win && (rd_state == R_IDLE) && (rd_cnt < MAX_CNT);
    ar_free    = (m_ar_valid && m_ar_ready) || ((rd_state == R_ERR) && s_r_ready && err_last);
    m_r_ready  = (rd_state == R_IDLE) && s_r_ready;
    if (rd_state == R_ERR) begin
      s_r_valid = 1'b1; s_r_id = m_ar_id; s_r_data = '0; s_r_resp = 2'b11; s_r_last = err_last;
    end else begin
      s_r_valid = m_r_valid; s_r_id = m_r_id; s_r_data = m_r_data; s_r_resp = m_r_resp;
      s_r_last = m_r_last;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE: if (aw_full && !aw_win) wr_next = W_SINK;
              else if (m_aw_valid && m_aw_ready) wr_next = W_FWD;
      W_FWD:  if (s_w_valid && s_w_ready && s_w_last) wr_next = W_IDLE;
      W_SINK: if (s_w_valid && s_w_last) wr_next = W_BERR;
      W_BERR: if (b_err && s_b_ready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // While W_BERR waits for the drain, forwarded B responses still pass through.
  always_comb begin
    b_err      = (wr_state == W_BERR) && (wr_cnt == 8'd0);
    m_aw_valid = aw_full && aw_win && (wr_state == W_IDLE) && (wr_cnt < MAX_CNT);
    aw_free    = (m_aw_valid && m_aw_ready) || (b_err && s_b_ready);
    m_w_valid  = (wr_state == W_FWD) && s_w_valid;
    m_w_data   = s_w_data;
    m_w_strb   = s_w_strb;
    m_w_last   = s_w_last;
    s_w_ready  = (wr_state == W_SINK) || ((wr_state == W_FWD) && m_w_ready);
    m_b_ready  = !b_err && s_b_ready;
    s_b_valid  = b_err ? 1'b1 : m_b_valid;
    s_b_id     = b_err ? m_aw_id : m_b_id;
    s_b_resp   = b_err ? 2'b11 : m_b_resp;
  end

  assign rd_inc = m_ar_valid && m_ar_ready;
  assign rd_dec = m_r_valid && m_r_ready && m_r_last && (rd_cnt != 8'd0);
  assign wr_inc = m_aw_valid && m_aw_ready;
  assign wr_dec = m_b_valid && m_b_ready && (wr_cnt != 8'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt <= 8'd0; wr_cnt <= 8'd0; err_beat <= 8'd0;
    end else begin
      if (rd_inc && !rd_dec) rd_cnt <= rd_cnt + 8'd1;
      else if (rd_dec && !rd_inc) rd_cnt <= rd_cnt - 8'd1;
      if (wr_inc && !wr_dec) wr_cnt <= wr_cnt + 8'd1;
      else if (wr_dec && !wr_inc) wr_cnt <= wr_cnt - 8'd1;
      if (rd_state != R_ERR) err_beat <= 8'd0;
      else if (s_r_ready) err_beat <= err_beat + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_mem_window.sv
// Self-checking bench for axi_mem_window: directed scenarios plus randomized reads/writes
// checked against an arithmetic window model.
module tb_axi_mem_window;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W = 6;
  localparam logic [31:0] IN_BASE = 32'h8000_0000;
  localparam logic [31:0] OUT_BASE = 32'h1000_0000;
  localparam int WIN_BITS = 28;
  localparam int MAX_OUT = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic s_ar_valid = 0, s_ar_ready, s_aw_valid = 0, s_aw_ready;
  logic [31:0] s_ar_addr = 0, s_aw_addr = 0;
  logic [5:0] s_ar_id = 0, s_aw_id = 0;
  logic [7:0] s_ar_len = 0, s_aw_len = 0;
  logic [2:0] s_ar_size = 0, s_aw_size = 0;
  logic [1:0] s_ar_burst = 0, s_aw_burst = 0;
  logic s_w_valid = 0, s_w_ready, s_w_last = 0;
  logic [63:0] s_w_data = 0;
  logic [7:0] s_w_strb = 0;
  logic s_r_valid, s_r_ready = 0, s_r_last;
  logic [5:0] s_r_id, s_b_id;
  logic [63:0] s_r_data;
  logic [1:0] s_r_resp, s_b_resp;
  logic s_b_valid, s_b_ready = 0;
  logic m_ar_valid, m_ar_ready = 0, m_aw_valid, m_aw_ready = 0;
  logic [31:0] m_ar_addr, m_aw_addr;
  logic [5:0] m_ar_id, m_aw_id;
  logic [7:0] m_ar_len, m_aw_len;
  logic [2:0] m_ar_size, m_aw_size;
  logic [1:0] m_ar_burst, m_aw_burst;
  logic m_w_valid, m_w_ready = 0, m_w_last;
  logic [63:0] m_w_data;
  logic [7:0] m_w_strb;
  logic m_r_valid = 0, m_r_ready, m_r_last = 0;
  logic [5:0] m_r_id = 0, m_b_id = 0;
  logic [63:0] m_r_data = 0;
  logic [1:0] m_r_resp = 0, m_b_resp = 0;
  logic m_b_valid = 0, m_b_ready;

  int checks = 0;
  int failures = 0;

  axi_mem_window #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE),
    .WIN_BITS(WIN_BITS), .MAX_OUT(MAX_OUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp)
  );

  always #5 clock = ~clock;

  // Reference model: the window is a plain address range, translation a base offset.
  function automatic bit modelInWin(input logic [31:0] a);
    longint unsigned av = longint'(a);
    return av >= longint'(IN_BASE) && av < longint'(IN_BASE) + (64'd1 << WIN_BITS);
  endfunction

  function automatic logic [31:0] modelXlate(input logic [31:0] a);
    return a - IN_BASE + OUT_BASE;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic arSend(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len);
    s_ar_valid = 1; s_ar_addr = addr; s_ar_id = id; s_ar_len = len; s_ar_size = 3; s_ar_burst = 1;
    #1 checkOutput("s_ar_ready", s_ar_ready, 1);
    tick;
    s_ar_valid = 0;
    #1;
  endtask

  task automatic awSend(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len);
    s_aw_valid = 1; s_aw_addr = addr; s_aw_id = id; s_aw_len = len; s_aw_size = 3; s_aw_burst = 1;
    #1 checkOutput("s_aw_ready", s_aw_ready, 1);
    tick;
    s_aw_valid = 0;
    #1;
  endtask

  task automatic rFwdBeats(input logic [5:0] id, input logic [7:0] len);
    for (int b = 0; b <= int'(len); b++) begin
      bit done = 0;
      int guard = 0;
      m_r_valid = 1; m_r_id = id; m_r_data = {$urandom, $urandom}; m_r_resp = 0;
      m_r_last = (b == int'(len));
      while (!done) begin
        s_r_ready = (guard > 8) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        checkOutput("r_fwd_valid", s_r_valid, 1);
        checkOutput("r_fwd_data", s_r_data, m_r_data);
        checkOutput("r_fwd_id", s_r_id, id);
        checkOutput("r_fwd_last", s_r_last, m_r_last);
        checkOutput("m_r_ready", m_r_ready, s_r_ready);
        done = s_r_ready;
        tick;
        guard++;
      end
    end
    m_r_valid = 0; m_r_last = 0; s_r_ready = 0;
  endtask

  task automatic rErrBeats(input logic [5:0] id, input logic [7:0] len, input int first, input int upto);
    for (int b = first; b < upto; b++) begin
      bit done = 0;
      int guard = 0;
      while (!done) begin
        s_r_ready = (guard > 8) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        checkOutput("r_err_valid", s_r_valid, 1);
        checkOutput("r_err_resp", s_r_resp, 2'b11);
        checkOutput("r_err_data", s_r_data, 0);
        checkOutput("r_err_id", s_r_id, id);
        checkOutput("r_err_last", s_r_last, b == int'(len));
        checkOutput("r_err_no_m_ar", m_ar_valid, 0);
        done = s_r_ready;
        tick;
        guard++;
      end
    end
    s_r_ready = 0;
  endtask

  task automatic readTxn(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len);
    arSend(addr, id, len);
    if (modelInWin(addr)) begin
      checkOutput("m_ar_valid", m_ar_valid, 1);
      checkOutput("m_ar_addr", m_ar_addr, modelXlate(addr));
      checkOutput("m_ar_id", m_ar_id, id);
      checkOutput("m_ar_len", m_ar_len, len);
      m_ar_ready = 1;
      tick;
      m_ar_ready = 0;
      rFwdBeats(id, len);
    end else begin
      checkOutput("oow_no_m_ar", m_ar_valid, 0);
      rErrBeats(id, len, 0, int'(len) + 1);
    end
    #1;
    checkOutput("rd_done_ar_ready", s_ar_ready, 1);
    checkOutput("rd_done_r_valid", s_r_valid, 0);
  endtask

  task automatic wFwd(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len);
    checkOutput("m_aw_valid", m_aw_valid, 1);
    checkOutput("m_aw_addr", m_aw_addr, modelXlate(addr));
    checkOutput("m_aw_id", m_aw_id, id);
    checkOutput("m_aw_len", m_aw_len, len);
    m_aw_ready = 1;
    tick;
    m_aw_ready = 0;
    for (int b = 0; b <= int'(len); b++) begin
      bit done = 0;
      int guard = 0;
      s_w_valid = 1; s_w_data = {$urandom, $urandom}; s_w_strb = 8'($urandom);
      s_w_last = (b == int'(len));
      while (!done) begin
        m_w_ready = (guard > 8) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        checkOutput("m_w_valid", m_w_valid, 1);
        checkOutput("m_w_data", m_w_data, s_w_data);
        checkOutput("m_w_strb", m_w_strb, s_w_strb);
        checkOutput("m_w_last", m_w_last, s_w_last);
        checkOutput("s_w_ready", s_w_ready, m_w_ready);
        done = m_w_ready;
        tick;
        guard++;
      end
    end
    s_w_valid = 0; s_w_last = 0; m_w_ready = 0;
  endtask

  task automatic wSink(input logic [7:0] len);
    for (int b = 0; b <= int'(len); b++) begin
      bit done = 0;
      int guard = 0;
      s_w_valid = 1; s_w_data = {$urandom, $urandom}; s_w_strb = 8'hFF; s_w_last = (b == int'(len));
      while (!done && guard < 20) begin
        #1;
        checkOutput("sink_no_m_w", m_w_valid, 0);
        done = s_w_ready;
        tick;
        guard++;
      end
      if (!done) checkOutput("sink_timeout", 0, 1);
    end
    s_w_valid = 0; s_w_last = 0;
  endtask

  task automatic bFwd(input logic [5:0] id, input logic [1:0] resp);
    bit done = 0;
    int guard = 0;
    m_b_valid = 1; m_b_id = id; m_b_resp = resp;
    while (!done) begin
      s_b_ready = (guard > 8) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      checkOutput("b_fwd_valid", s_b_valid, 1);
      checkOutput("b_fwd_id", s_b_id, id);
      checkOutput("b_fwd_resp", s_b_resp, resp);
      checkOutput("m_b_ready", m_b_ready, s_b_ready);
      done = s_b_ready;
      tick;
      guard++;
    end
    m_b_valid = 0; s_b_ready = 0;
    #1;
  endtask

  task automatic bErr(input logic [5:0] id);
    int guard = 0;
    while (!s_b_valid && guard < 20) begin
      tick;
      guard++;
    end
    checkOutput("b_err_valid", s_b_valid, 1);
    checkOutput("b_err_resp", s_b_resp, 2'b11);
    checkOutput("b_err_id", s_b_id, id);
    s_b_ready = 1;
    tick;
    s_b_ready = 0;
    #1;
    checkOutput("b_err_cleared", s_b_valid, 0);
  endtask

  task automatic writeTxn(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len);
    awSend(addr, id, len);
    if (modelInWin(addr)) begin
      wFwd(addr, id, len);
      bFwd(id, 2'($urandom_range(0, 3)));
    end else begin
      checkOutput("oow_no_m_aw", m_aw_valid, 0);
      wSink(len);
      bErr(id);
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] addr = $urandom_range(0, 1) ? (IN_BASE + ($urandom & 32'h0FFF_FFF8)) : $urandom;
      logic [5:0] id = 6'($urandom);
      logic [7:0] len = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 1)) readTxn(addr, id, len);
      else writeTxn(addr, id, len);
    end
  endtask

  initial begin
    reset_n = 0;
    tick;
    tick;
    checkOutput("rst_ar_ready", s_ar_ready, 1);
    checkOutput("rst_aw_ready", s_aw_ready, 1);
    checkOutput("rst_m_ar_valid", m_ar_valid, 0);
    checkOutput("rst_m_aw_valid", m_aw_valid, 0);
    checkOutput("rst_s_r_valid", s_r_valid, 0);
    checkOutput("rst_s_b_valid", s_b_valid, 0);
    checkOutput("rst_s_w_ready", s_w_ready, 0);
    checkOutput("rst_m_ar_addr", m_ar_addr, 0);
    checkOutput("rst_m_aw_addr", m_aw_addr, 0);
    reset_n = 1;
    tick;

    readTxn(32'h8000_1040, 6'd3, 8'd3);
    writeTxn(32'h8FFF_FFC0, 6'd4, 8'd1);
    readTxn(32'h4000_0000, 6'd5, 8'd7);
    readTxn(32'h7FFF_FFF8, 6'd6, 8'd0);
    readTxn(32'h8000_0000, 6'd7, 8'd0);
    readTxn(32'h8FFF_FFF8, 6'd8, 8'd1);
    readTxn(32'h9000_0000, 6'd9, 8'd0);

    // Out-of-window write behind two forwarded writes still awaiting B.
    awSend(32'h8000_0100, 6'd1, 8'd0);
    wFwd(32'h8000_0100, 6'd1, 8'd0);
    awSend(32'h8000_0200, 6'd2, 8'd1);
    wFwd(32'h8000_0200, 6'd2, 8'd1);
    awSend(32'h4000_0000, 6'd9, 8'd2);
    wSink(8'd2);
    tick;
    checkOutput("berr_wait2", s_b_valid, 0);
    tick;
    checkOutput("berr_wait2b", s_b_valid, 0);
    bFwd(6'd1, 2'b00);
    checkOutput("berr_wait1", s_b_valid, 0);
    bFwd(6'd2, 2'b00);
    checkOutput("berr_after_drain", s_b_valid, 1);
    bErr(6'd9);

    // Outstanding-read limit: the third request waits for the first rlast.
    arSend(32'h8000_0010, 6'd10, 8'd0);
    m_ar_ready = 1; tick; m_ar_ready = 0;
    arSend(32'h8000_0020, 6'd11, 8'd0);
    m_ar_ready = 1; tick; m_ar_ready = 0;
    arSend(32'h8000_0030, 6'd12, 8'd0);
    checkOutput("limit_hold0", m_ar_valid, 0);
    m_r_valid = 1; m_r_id = 6'd10; m_r_last = 1; m_r_data = 64'h1234;
    for (int k = 0; k < 3; k++) begin
      tick;
      checkOutput("limit_hold", m_ar_valid, 0);
      checkOutput("limit_r_stall", m_r_ready, 0);
    end
    s_r_ready = 1;
    tick;
    m_r_valid = 0; m_r_last = 0; s_r_ready = 0;
    #1;
    checkOutput("limit_release", m_ar_valid, 1);
    checkOutput("limit_addr", m_ar_addr, modelXlate(32'h8000_0030));
    m_ar_ready = 1; tick; m_ar_ready = 0;
    rFwdBeats(6'd11, 8'd0);
    rFwdBeats(6'd12, 8'd0);

    // Asynchronous reset in the middle of a DECERR burst.
    arSend(32'h4000_0000, 6'd5, 8'd7);
    rErrBeats(6'd5, 8'd7, 0, 2);
    #2 reset_n = 0;
    #1;
    checkOutput("arst_r_valid", s_r_valid, 0);
    checkOutput("arst_ar_ready", s_ar_ready, 1);
    checkOutput("arst_m_ar_valid", m_ar_valid, 0);
    checkOutput("arst_b_valid", s_b_valid, 0);
    tick;
    reset_n = 1;
    tick;
    readTxn(32'h8000_2000, 6'd21, 8'd2);
    readTxn(32'h2000_0000, 6'd22, 8'd1);

    applyStimulus(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi_mem_window.md
# axi_mem_window

Parametrised AXI4 address-window bridge between the Rocket `Top` memory master port (`io_mem_axi_*`) and the Zynq PS HP slave port (`S_AXI_*`). It generalises the fixed "upper 256 MB" remap into a configurable window, and adds one register-slice stage on AR/AW plus outstanding-transaction limiting. Accesses outside the window get a locally generated DECERR response instead of being forwarded into PS DRAM.

## Interface
Parameters:
- `ADDR_W`, 32: address width, both sides.
- `DATA_W`, 64: data width; strobe width is `DATA_W/8`.
- `ID_W`, 6: AXI ID width.
- `IN_BASE`, 32'h8000_0000: base of the Rocket-side window; must be aligned to 2^`WIN_BITS`.
- `OUT_BASE`, 32'h1000_0000: PS-side base; must be aligned to 2^`WIN_BITS`.
- `WIN_BITS`, 28: window size is 2^`WIN_BITS` bytes.
- `MAX_OUT`, 8: maximum forwarded transactions in flight per direction (1..255).

Ports. Channels are grouped; `s_` faces Rocket (slave side), `m_` faces the PS (master side):
- `clock` in 1: single clock, host_clk domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_ar_valid`/`s_ar_ready` in/out 1; `s_ar_addr` in ADDR_W; `s_ar_id` in ID_W; `s_ar_len` in 8; `s_ar_size` in 3; `s_ar_burst` in 2.
- `s_aw_*`: same set as `s_ar_*`.
- `s_w_valid` in, `s_w_ready` out; `s_w_data` in DATA_W; `s_w_strb` in DATA_W/8; `s_w_last` in 1.
- `s_r_valid` out, `s_r_ready` in; `s_r_id` out ID_W; `s_r_data` out DATA_W; `s_r_resp` out 2; `s_r_last` out 1.
- `s_b_valid` out, `s_b_ready` in; `s_b_id` out ID_W; `s_b_resp` out 2.
- `m_ar_*`, `m_aw_*`, `m_w_*`, `m_r_*`, `m_b_*`: mirror images of the above with directions reversed.

## Operation
- In-window test: `addr[ADDR_W-1:WIN_BITS] == IN_BASE[ADDR_W-1:WIN_BITS]`. Translation: `m_addr = OUT_BASE[ADDR_W-1:WIN_BITS] ++ addr[WIN_BITS-1:0]`. All other AR/AW fields pass unchanged.
- Read path:
  - 1-entry AR slice; `s_ar_ready` = slice empty.
  - In-window entry with `rd_cnt < MAX_OUT`: drive `m_ar_valid`. On `m_ar` handshake: slice empties, `rd_cnt`++.
  - Out-of-window entry: wait for `rd_cnt == 0`, then enter R_ERR.
  - R_ERR emits `len+1` beats: `s_r_id` = entry ID, data 0, resp 2'b11, `s_r_last` on the final beat. Each beat advances on `s_r_ready`. The slice frees after the last beat.
  - Outside R_ERR, `m_r_*` passes combinationally to `s_r_*`. `rd_cnt`-- on an `m_r` handshake with `last`.
- Write path FSM:
  - W_IDLE: AW slice in-window and `wr_cnt < MAX_OUT` → drive `m_aw_valid`; on handshake, `wr_cnt`++ and go to W_FWD. Out-of-window → W_SINK.
  - W_FWD: W passes combinationally. On `s_w` handshake with `last` → W_IDLE.
  - W_SINK: `s_w_ready`=1, `m_w_valid`=0. Beats are discarded; on `last` → W_BERR.
  - W_BERR: wait for `wr_cnt == 0`, then assert `s_b_valid` with resp 2'b11 and the slice ID. On `s_b_ready` → W_IDLE.
  - The AW slice frees on leaving W_IDLE (fwd) or on leaving W_BERR (err).
  - Outside W_BERR, `m_b_*` passes to `s_b_*`. `wr_cnt`-- on an `m_b` handshake.
- Counter increment and decrement in the same cycle leave the count unchanged. The count never exceeds `MAX_OUT` and never underflows.

## Timing
- Reset values:
  - `s_ar_ready`=`s_aw_ready`=1.
  - All other valids/readies 0.
  - All `m_` payloads and `s_r_*`/`s_b_*` payloads 0.
  - Counters 0; FSMs in IDLE.
- AR/AW latency: `s_` handshake in cycle N → `m_ar_valid`/`m_aw_valid` in N+1 at earliest. Full throughput is not required: one request per 2 cycles.
- R/W/B forwarded paths: zero-cycle combinational.
- Error reads: first DECERR beat in the cycle after `rd_cnt` reaches 0 (or N+1 if already 0). Error B: cycle after W_BERR entry with `wr_cnt == 0`.
- Valid is held stable until ready on every output channel. A payload never changes while valid is high and ready is low.
- Asynchronous reset mid-burst: all state clears immediately. No partial beat is reissued.

## Test plan
- In-window read, `s_ar_addr`=32'h8000_1040, len 3 → `m_ar_addr`=32'h1000_1040 one cycle later. 4 R beats pass with IDs intact. `rd_cnt` returns to 0.
- In-window write, addr 32'h8FFF_FFC0, len 1, 2 W beats → `m_aw_addr`=32'h1FFF_FFC0. W forwarded unchanged. B relayed with `m_b` resp 0.
- Out-of-window read, addr 32'h4000_0000, len 7, id 5 → no `m_ar_valid`. 8 R beats with resp 3, data 0, id 5, `last` on beat 8, under random `s_r_ready` stalls.
- Out-of-window write issued while 2 forwarded writes are pending → W beats sunk. `s_b_valid` resp 3 only after both `m_b` responses complete.
- `MAX_OUT`=2, 3 back-to-back in-window reads with `m_r_ready` stalled → third `m_ar_valid` held until the first `rlast` handshake.
- `reset_n` pulsed low mid-R_ERR burst → all valids 0 asynchronously, `s_ar_ready`=1. A fresh read afterwards completes correctly.
